// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and polled status.
// Optional even-parity bit is built when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int CLK_DIV_DEFAULT = 234,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] data_addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   baud_div;
    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [15:0]   timer, div_q;
    logic [1:0]    sel;
    logic          full, empty, push_req, push, pop, tick;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel      = data_addr[3:2];
    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign push_req = wen && sel == 2'd0;
    assign push     = push_req && !full;
    assign tick     = timer == 16'd0;
    assign pop      = !empty && (state == IDLE || (state == STOP && tick));
    assign tx_busy  = !empty || state != IDLE;
    assign status   = {16'b0, 8'(count), 3'b0, PAR_EN, overflow, empty, full, tx_busy};
    assign data_out = sel == 2'd1 ? status : sel == 2'd2 ? {16'b0, baud_div} : 32'b0;
    assign unused_bits = ^{ren, data_addr[31:4], data_addr[1:0], data_in[31:16]};

    // FIFO storage: no reset needed, validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in[7:0];
    end

    // FIFO pointers, occupancy, sticky overflow and the baud divisor register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= 16'(CLK_DIV_DEFAULT);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (push_req && full) overflow <= 1'b1;
            else if (wen && sel == 2'd1 && data_in[3]) overflow <= 1'b0;
            if (wen && sel == 2'd2) baud_div <= data_in[15:0] < 16'd2 ? 16'd2 : data_in[15:0];
        end
    end

    // Shifter FSM; the divisor is latched per frame so mid-frame writes wait for the next one
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
            timer   <= '0;
            div_q   <= '0;
        end else begin
            if (state != IDLE && !tick) timer <= timer - 16'd1;
            case (state)
                IDLE, STOP: if (state == IDLE || tick) begin
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                        shreg <= mem[rd_ptr];
                        div_q <= baud_div;
                        timer <= baud_div - 16'd1;
                    end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end
                START: if (tick) begin
                    state   <= DATA;
                    tx      <= shreg[0];
                    bit_idx <= '0;
                    timer   <= div_q - 16'd1;
                end
                DATA: if (tick) begin
                    timer   <= div_q - 16'd1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= ^shreg;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        tx <= shreg[bit_idx + 3'd1];
                    end
                end
                PARITY: if (tick) begin
                    state <= STOP;
                    tx    <= 1'b1;
                    timer <= div_q - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
